// File: rtl/cache_mem_pkg.sv
// rtl/cache_mem_pkg.sv - shared types and line geometry for the cache/memory arbiter
package cache_mem_pkg;
   localparam int LINE_WORDS = 4;
   localparam int WORD_IDX_W = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DONE
   } arb_state_t;

   typedef enum logic {
      OWNER_IC,
      OWNER_DC
   } owner_t;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side and memory-side bus of the arbiter
interface cache_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = 2
);
   logic                  ic_req_i;
   logic [ADDR_WIDTH-1:0] ic_addr_i;
   logic                  ic_rvalid_o;
   logic                  ic_done_o;
   logic                  dc_req_i;
   logic                  dc_we_i;
   logic [ADDR_WIDTH-1:0] dc_addr_i;
   logic [DATA_WIDTH-1:0] dc_wdata_i;
   logic                  dc_rvalid_o;
   logic                  dc_done_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic [IDX_W-1:0]      word_idx_o;
   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  mem_ack_i;
   logic                  stall_o;

   modport slave (
      input  ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
             mem_rdata_i, mem_ack_i,
      output ic_rvalid_o, ic_done_o, dc_rvalid_o, dc_done_o, rdata_o, word_idx_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
   );

   modport master (
      output ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
             mem_rdata_i, mem_ack_i,
      input  ic_rvalid_o, ic_done_o, dc_rvalid_o, dc_done_o, rdata_o, word_idx_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
   );
endinterface

// File: rtl/arb_grant_select.sv
// rtl/arb_grant_select.sv - picks the next port owner; ARB_ROUND_ROBIN_EN selects round-robin
// over fixed D-cache priority when both caches request together.
module arb_grant_select
   import cache_mem_pkg::*;
(
   input  logic   icReq,
   input  logic   dcReq,
   input  owner_t lastGrant,
   output owner_t winner
);
   always_comb begin
      winner = OWNER_IC;
      if (icReq && dcReq) begin
`ifdef ARB_ROUND_ROBIN_EN
         winner = (lastGrant == OWNER_IC) ? OWNER_DC : OWNER_IC;
`else
         winner = OWNER_DC;
`endif
      end else if (dcReq) begin
         winner = OWNER_DC;
      end
   end

`ifndef ARB_ROUND_ROBIN_EN
   // Fixed priority has no history; keep the port for a uniform instance.
   logic unusedLastGrant;
   assign unusedLastGrant = (lastGrant == OWNER_DC);
`endif
endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one memory port between I/D-cache line bursts and drives
// the pipeline stall; ARB_ROUND_ROBIN_EN enables round-robin grant on simultaneous requests.
module cache_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = cache_mem_pkg::LINE_WORDS
) (
   input logic               clk_i,
   input logic               rst_i,
   cache_mem_arbiter_if.slave bus
);
   import cache_mem_pkg::*;

   localparam int IDX_W = $clog2(LINE_WORDS);

   arb_state_t            state, stateNext;
   owner_t                owner, lastGrant, winner;
   logic                  weQ;
   logic [ADDR_WIDTH-1:0] baseQ;
   logic [IDX_W-1:0]      cnt;
   logic                  anyReq;

   logic                  memReq, memWe, icRvalid, dcRvalid, icDone, dcDone;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [DATA_WIDTH-1:0] memWdata, rdata;
   logic [IDX_W-1:0]      wordIdx;

   assign anyReq = bus.ic_req_i | bus.dc_req_i;

   arb_grant_select uGrant (
      .icReq     (bus.ic_req_i),
      .dcReq     (bus.dc_req_i),
      .lastGrant (lastGrant),
      .winner    (winner)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner     <= OWNER_IC;
         lastGrant <= OWNER_IC;
         weQ       <= 1'b0;
         baseQ     <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (anyReq) begin
                  owner     <= winner;
                  lastGrant <= winner;
                  // The I-cache is read-only, so its dc_we_i view is masked off.
                  weQ       <= (winner == OWNER_DC) && bus.dc_we_i;
                  baseQ     <= (winner == OWNER_DC) ? bus.dc_addr_i : bus.ic_addr_i;
                  cnt       <= '0;
               end
            end
            BURST: begin
               if (bus.mem_ack_i) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stateNext = state;
      memReq    = 1'b0;
      memWe     = 1'b0;
      memAddr   = '0;
      memWdata  = '0;
      wordIdx   = '0;
      rdata     = '0;
      icRvalid  = 1'b0;
      dcRvalid  = 1'b0;
      icDone    = 1'b0;
      dcDone    = 1'b0;
      case (state)
         IDLE: begin
            if (anyReq) begin
               stateNext = BURST;
            end
         end
         BURST: begin
            memReq   = 1'b1;
            memWe    = weQ;
            memAddr  = baseQ + (ADDR_WIDTH'(cnt) << 2);
            memWdata = bus.dc_wdata_i;
            wordIdx  = cnt;
            if (bus.mem_ack_i) begin
               if (!weQ) begin
                  rdata    = bus.mem_rdata_i;
                  icRvalid = (owner == OWNER_IC);
                  dcRvalid = (owner == OWNER_DC);
               end
               if (cnt == IDX_W'(LINE_WORDS - 1)) begin
                  stateNext = DONE;
               end
            end
         end
         DONE: begin
            icDone    = (owner == OWNER_IC);
            dcDone    = (owner == OWNER_DC);
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign bus.mem_req_o   = memReq;
   assign bus.mem_we_o    = memWe;
   assign bus.mem_addr_o  = memAddr;
   assign bus.mem_wdata_o = memWdata;
   assign bus.word_idx_o  = wordIdx;
   assign bus.rdata_o     = rdata;
   assign bus.ic_rvalid_o = icRvalid;
   assign bus.dc_rvalid_o = dcRvalid;
   assign bus.ic_done_o   = icDone;
   assign bus.dc_done_o   = dcDone;
   assign bus.stall_o     = (state != IDLE) | anyReq;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
   import cache_mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared = 0;
   int   mismatched = 0;

   cache_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IDX_W(WORD_IDX_W)) bus ();

   cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(LINE_WORDS)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory returns a tag plus the low address bits; D-cache supplies tagged word index.
   assign bus.mem_rdata_i = {16'hD00D, bus.mem_addr_o[15:0]};
   assign bus.dc_wdata_i  = 32'hCAFE_0000 | 32'(bus.word_idx_o);

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst = 1'b1;
      bus.ic_req_i = 1'b0; bus.ic_addr_i = '0;
      bus.dc_req_i = 1'b0; bus.dc_we_i = 1'b0; bus.dc_addr_i = '0;
      bus.mem_ack_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.ic_rvalid_o, bus.dc_rvalid_o,
           bus.ic_done_o, bus.dc_done_o, bus.stall_o} !== 7'b0) begin
         mismatched++;
         $display("FAIL reset_ctrl got %b want 0", {bus.mem_req_o, bus.mem_we_o,
                  bus.ic_rvalid_o, bus.dc_rvalid_o, bus.ic_done_o, bus.dc_done_o, bus.stall_o});
      end
      compared++;
      if ({bus.mem_addr_o, bus.mem_wdata_o, bus.rdata_o, bus.word_idx_o} !== '0) begin
         mismatched++;
         $display("FAIL reset_data got %h/%h/%h/%h want 0", bus.mem_addr_o, bus.mem_wdata_o,
                  bus.rdata_o, bus.word_idx_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_ic_refill();
      bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h100; bus.mem_ack_i = 1'b1;
      @(negedge clk);
      compared++;
      if ({bus.mem_req_o, bus.stall_o} !== 2'b01) begin
         mismatched++;
         $display("FAIL ic_latency req/stall got %b want 01", {bus.mem_req_o, bus.stall_o});
      end
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         @(negedge clk);
         compared++;
         if (bus.mem_addr_o !== 32'h100 + 32'(4 * b)) begin
            mismatched++;
            $display("FAIL ic_addr beat %0d got %h want %h", b, bus.mem_addr_o, 32'h100 + 32'(4 * b));
         end
         compared++;
         if ({bus.mem_req_o, bus.mem_we_o, bus.ic_rvalid_o, bus.dc_rvalid_o} !== 4'b1010) begin
            mismatched++;
            $display("FAIL ic_beat_ctrl %0d got %b want 1010", b,
                     {bus.mem_req_o, bus.mem_we_o, bus.ic_rvalid_o, bus.dc_rvalid_o});
         end
         compared++;
         if (bus.rdata_o !== 32'hD00D_0100 + 32'(4 * b)) begin
            mismatched++;
            $display("FAIL ic_rdata beat %0d got %h want %h", b, bus.rdata_o, 32'hD00D_0100 + 32'(4 * b));
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      compared++;
      if ({bus.ic_done_o, bus.dc_done_o, bus.mem_req_o, bus.stall_o} !== 4'b1001) begin
         mismatched++;
         $display("FAIL ic_done got %b want 1001",
                  {bus.ic_done_o, bus.dc_done_o, bus.mem_req_o, bus.stall_o});
      end
      @(posedge clk); #1;
      bus.ic_req_i = 1'b0;
      @(negedge clk);
      compared++;
      if ({bus.stall_o, bus.ic_done_o, bus.mem_req_o} !== 3'b000) begin
         mismatched++;
         $display("FAIL ic_idle got %b want 000", {bus.stall_o, bus.ic_done_o, bus.mem_req_o});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_dc_writeback();
      int ackSeq [6] = '{1, 0, 0, 1, 1, 1};
      int idxSeq [6] = '{0, 1, 1, 1, 2, 3};
      bus.dc_req_i = 1'b1; bus.dc_we_i = 1'b1; bus.dc_addr_i = 32'h200; bus.mem_ack_i = 1'b0;
      @(negedge clk);
      compared++;
      if ({bus.mem_req_o, bus.stall_o} !== 2'b01) begin
         mismatched++;
         $display("FAIL wb_latency got %b want 01", {bus.mem_req_o, bus.stall_o});
      end
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         bus.mem_ack_i = ackSeq[c][0];
         @(negedge clk);
         compared++;
         if ({bus.mem_addr_o, bus.word_idx_o} !== {32'h200 + 32'(4 * idxSeq[c]), 2'(idxSeq[c])}) begin
            mismatched++;
            $display("FAIL wb_addr cyc %0d got %h/%0d want %h/%0d", c, bus.mem_addr_o,
                     bus.word_idx_o, 32'h200 + 32'(4 * idxSeq[c]), idxSeq[c]);
         end
         compared++;
         if (bus.mem_wdata_o !== 32'hCAFE_0000 + 32'(idxSeq[c])) begin
            mismatched++;
            $display("FAIL wb_wdata cyc %0d got %h want %h", c, bus.mem_wdata_o,
                     32'hCAFE_0000 + 32'(idxSeq[c]));
         end
         compared++;
         if ({bus.mem_req_o, bus.mem_we_o, bus.ic_rvalid_o, bus.dc_rvalid_o} !== 4'b1100) begin
            mismatched++;
            $display("FAIL wb_ctrl cyc %0d got %b want 1100", c,
                     {bus.mem_req_o, bus.mem_we_o, bus.ic_rvalid_o, bus.dc_rvalid_o});
         end
      end
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      @(negedge clk);
      compared++;
      if ({bus.dc_done_o, bus.ic_done_o, bus.mem_req_o, bus.mem_we_o, bus.dc_rvalid_o} !== 5'b10000) begin
         mismatched++;
         $display("FAIL wb_done got %b want 10000",
                  {bus.dc_done_o, bus.ic_done_o, bus.mem_req_o, bus.mem_we_o, bus.dc_rvalid_o});
      end
      @(posedge clk); #1;
      bus.dc_req_i = 1'b0; bus.dc_we_i = 1'b0;
      @(negedge clk);
      compared++;
      if (bus.stall_o !== 1'b0) begin
         mismatched++;
         $display("FAIL wb_idle_stall got %b want 0", bus.stall_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_simultaneous();
`ifdef ARB_ROUND_ROBIN_EN
      logic        expDc   [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] expAddr [3] = '{32'h400, 32'h300, 32'h500};
`else
      logic        expDc   [3] = '{1'b1, 1'b1, 1'b0};
      logic [31:0] expAddr [3] = '{32'h400, 32'h500, 32'h300};
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h300;
      bus.dc_req_i = 1'b1; bus.dc_we_i = 1'b0; bus.dc_addr_i = 32'h400;
      bus.mem_ack_i = 1'b1;
      @(negedge clk);
      compared++;
      if ({bus.mem_req_o, bus.stall_o} !== 2'b01) begin
         mismatched++;
         $display("FAIL sim_latency got %b want 01", {bus.mem_req_o, bus.stall_o});
      end
      for (int g = 0; g < 3; g++) begin
         for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            @(negedge clk);
            compared++;
            if ({bus.mem_addr_o, bus.ic_rvalid_o, bus.dc_rvalid_o, bus.stall_o} !==
                {expAddr[g] + 32'(4 * b), ~expDc[g], expDc[g], 1'b1}) begin
               mismatched++;
               $display("FAIL sim_beat g%0d b%0d got %h/%b%b%b want %h/%b%b1", g, b, bus.mem_addr_o,
                        bus.ic_rvalid_o, bus.dc_rvalid_o, bus.stall_o,
                        expAddr[g] + 32'(4 * b), ~expDc[g], expDc[g]);
            end
         end
         @(posedge clk); #1;
         @(negedge clk);
         compared++;
         if ({bus.ic_done_o, bus.dc_done_o, bus.stall_o} !== {~expDc[g], expDc[g], 1'b1}) begin
            mismatched++;
            $display("FAIL sim_done g%0d got %b want %b", g,
                     {bus.ic_done_o, bus.dc_done_o, bus.stall_o}, {~expDc[g], expDc[g], 1'b1});
         end
         @(posedge clk); #1;
         if (g == 0) begin
            bus.dc_addr_i = 32'h500;
         end else if (expDc[g]) begin
            bus.dc_req_i = 1'b0;
         end else begin
            bus.ic_req_i = 1'b0;
         end
         @(negedge clk);
         compared++;
         if ({bus.mem_req_o, bus.stall_o} !== {1'b0, (g < 2)}) begin
            mismatched++;
            $display("FAIL sim_idle g%0d got %b want %b", g, {bus.mem_req_o, bus.stall_o},
                     {1'b0, (g < 2)});
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_burst();
      bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h600; bus.mem_ack_i = 1'b1;
      for (int b = 0; b < 2; b++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      rst = 1'b1; bus.ic_req_i = 1'b0; bus.mem_ack_i = 1'b0;
      @(negedge clk);
      compared++;
      if ({bus.mem_addr_o, bus.word_idx_o} !== {32'h608, 2'd2}) begin
         mismatched++;
         $display("FAIL rst_pre_beat got %h/%0d want 608/2", bus.mem_addr_o, bus.word_idx_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if ({bus.mem_req_o, bus.stall_o, bus.ic_rvalid_o, bus.word_idx_o, bus.mem_addr_o} !== '0) begin
         mismatched++;
         $display("FAIL rst_after got %b%b%b/%0d/%h want 0", bus.mem_req_o, bus.stall_o,
                  bus.ic_rvalid_o, bus.word_idx_o, bus.mem_addr_o);
      end
      @(posedge clk); #1;
      bus.ic_req_i = 1'b1; bus.mem_ack_i = 1'b1;
      @(negedge clk);
      compared++;
      if ({bus.mem_req_o, bus.stall_o} !== 2'b01) begin
         mismatched++;
         $display("FAIL rst_rereq got %b want 01", {bus.mem_req_o, bus.stall_o});
      end
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         @(negedge clk);
         compared++;
         if ({bus.mem_addr_o, bus.word_idx_o, bus.ic_rvalid_o} !== {32'h600 + 32'(4 * b), 2'(b), 1'b1}) begin
            mismatched++;
            $display("FAIL rst_restart b%0d got %h/%0d/%b want %h/%0d/1", b, bus.mem_addr_o,
                     bus.word_idx_o, bus.ic_rvalid_o, 32'h600 + 32'(4 * b), b);
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      compared++;
      if (bus.ic_done_o !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_restart_done got %b want 1", bus.ic_done_o);
      end
      @(posedge clk); #1;
      bus.ic_req_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h100; bus.mem_ack_i = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      compared++;
      if (bus.ic_done_o !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_first_done got %b want 1", bus.ic_done_o);
      end
      @(posedge clk); #1;
      bus.ic_addr_i = 32'h140;
      @(negedge clk);
      compared++;
      if ({bus.mem_req_o, bus.stall_o, bus.ic_done_o} !== 3'b010) begin
         mismatched++;
         $display("FAIL b2b_idle got %b want 010", {bus.mem_req_o, bus.stall_o, bus.ic_done_o});
      end
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         @(negedge clk);
         compared++;
         if ({bus.mem_req_o, bus.mem_addr_o, bus.rdata_o} !==
             {1'b1, 32'h140 + 32'(4 * b), 32'hD00D_0140 + 32'(4 * b)}) begin
            mismatched++;
            $display("FAIL b2b_beat b%0d got %b/%h/%h want 1/%h/%h", b, bus.mem_req_o,
                     bus.mem_addr_o, bus.rdata_o, 32'h140 + 32'(4 * b), 32'hD00D_0140 + 32'(4 * b));
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      compared++;
      if (bus.ic_done_o !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_second_done got %b want 1", bus.ic_done_o);
      end
      @(posedge clk); #1;
      bus.ic_req_i = 1'b0;
      @(negedge clk);
      compared++;
      if (bus.stall_o !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b_final_stall got %b want 0", bus.stall_o);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_ic_refill();
      test_dc_writeback();
      test_simultaneous();
      test_reset_mid_burst();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
